// File: rtl/gfsk_mod.sv
// gfsk_mod: GFSK modulator. Synchronizes the NRZ bit stream, samples it five
// times per bit, Gaussian-filters the samples into an 11-bit frequency word
// centred on FWC_CENTER, and drives a 16-bit DDS whose phase addresses a
// 256-entry sine table. The output is an offset-binary DAC sample (128 = zero).
// Constants assume a 50 MHz sys_clk and a 1 Mbit/s input.
`timescale 1ns/1ps
module gfsk_mod #(
    parameter int unsigned SPS_DIV    = 10,
    parameter logic [10:0] FWC_CENTER = 11'd1311
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        data_in,
    output logic [7:0]  da_data,
    output logic        da_clk,
    output logic [10:0] fwc
);

    localparam int unsigned    CNT_W    = (SPS_DIV > 1) ? $clog2(SPS_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS_DIV - 1);
    localparam int             NTAPS    = 15;

    // Gaussian taps, BT ~ 0.5 over three bits; they sum to 328 (h = 0.5).
    localparam logic [10:0] COEF [NTAPS] = '{
        11'd0, 11'd0, 11'd0, 11'd1, 11'd8, 11'd32, 11'd74, 11'd98,
        11'd74, 11'd32, 11'd8, 11'd1, 11'd0, 11'd0, 11'd0
    };

    // First quarter of the sine: round(127.5 + 127.5*sin(2*pi*k/256)), k = 0..64.
    localparam logic [7:0] QUARTER [65] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149, 8'd152, 8'd155,
        8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173, 8'd176, 8'd179, 8'd182, 8'd185,
        8'd188, 8'd190, 8'd193, 8'd196, 8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211,
        8'd213, 8'd215, 8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244, 8'd245, 8'd246,
        8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252, 8'd253, 8'd253, 8'd254, 8'd254,
        8'd254, 8'd255, 8'd255, 8'd255, 8'd255
    };

    // Full-wave lookup built from the quarter table. The negative half mirrors
    // as 255 - q, which equals round-half-up of 127.5 - x everywhere except the
    // zero crossing at address 128, where the exact value 128 is forced.
    function automatic logic [7:0] sine_lut(input logic [7:0] addr);
        logic [6:0] ofs;
        logic [6:0] idx;
        logic [7:0] q;
        ofs = addr[6:0];
        idx = ofs[6] ? (~ofs + 7'd1) : ofs;
        q   = QUARTER[idx];
        if (!addr[7])
            sine_lut = q;
        else if (ofs == 7'd0)
            sine_lut = 8'd128;
        else
            sine_lut = 8'd255 - q;
    endfunction

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             strobe;
    logic [1:0]       taps [NTAPS];
    logic [10:0]      fwc_next;
    logic [15:0]      phase;

    assign strobe = (cnt == CNT_LAST);

    // DAC latches on its rising edge, i.e. mid-way between our update edges.
    assign da_clk = ~sys_clk;

    // Two-flop synchronizer for the asynchronous bit stream.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= data_in;
            sync2 <= sync1;
        end
    end

    // Sample-rate divider; strobe on the last count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt <= '0;
        else if (strobe)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Delay line of signed symbols: 01 = +1, 11 = -1, 00 = empty after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                taps[i] <= 2'b00;
        end else if (strobe) begin
            taps[0] <= sync2 ? 2'b01 : 2'b11;
            for (int i = 1; i < NTAPS; i++)
                taps[i] <= taps[i-1];
        end
    end

    // FIR accumulated directly on top of the centre word; partial sums stay
    // within 983..1639, so unsigned 11-bit arithmetic never wraps.
    always_comb begin
        fwc_next = FWC_CENTER;
        for (int i = 0; i < NTAPS; i++) begin
            if (taps[i] == 2'b01)
                fwc_next = fwc_next + COEF[i];
            else if (taps[i] == 2'b11)
                fwc_next = fwc_next - COEF[i];
        end
    end

    // Registered frequency word, DDS accumulator and DAC sample pipeline.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fwc     <= FWC_CENTER;
            phase   <= 16'd0;
            da_data <= 8'd128;
        end else begin
            fwc     <= fwc_next;
            phase   <= phase + {5'd0, fwc};
            da_data <= sine_lut(phase[15:8]);
        end
    end

endmodule

// File: tb/tb_gfsk_mod.sv
// Testbench for gfsk_mod: a reference model pushes the expected fwc/da_data
// for every clock into a queue; a monitor pops and compares one entry per
// cycle. Directed phases add hand-computed checks on settled values.
`timescale 1ns/1ps
module tb_gfsk_mod;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        data_in;
    logic [7:0]  da_data;
    logic        da_clk;
    logic [10:0] fwc;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int fwc;
        int da;
    } exp_t;

    exp_t exp_q[$];

    localparam int COEF [15] = '{0, 0, 0, 1, 8, 32, 74, 98, 74, 32, 8, 1, 0, 0, 0};
    int lut_tab [256];

    // Flags set by the stimulus to enable phase-specific monitor checks.
    bit delta_en     = 0;
    bit range_strict = 0;
    bit range_incl   = 0;
    bit alt_track    = 0;
    int alt_max      = 0;
    int alt_min      = 4096;

    gfsk_mod dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data_in   (data_in),
        .da_data   (da_data),
        .da_clk    (da_clk),
        .fwc       (fwc)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
        #2;
    endtask

    // Sine table from floating point, round-half-up.
    initial begin
        for (int k = 0; k < 256; k++)
            lut_tab[k] = $rtoi($floor(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0) + 0.5));
    end

    // Reference model: synchronizer, sample divider, tap line, FIR, DDS, LUT.
    initial begin
        int   m_taps [15];
        logic m_s1, m_s2;
        int   m_cnt, m_fwc, m_da, s, n_da;
        logic [15:0] m_phase;
        exp_t e;
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_fwc = 1311; m_da = 128; m_phase = 0;
        for (int i = 0; i < 15; i++) m_taps[i] = 0;
        forever begin
            @(posedge sys_clk);
            if (!sys_rst_n) begin
                m_s1 = 0; m_s2 = 0; m_cnt = 0; m_fwc = 1311; m_da = 128; m_phase = 0;
                for (int i = 0; i < 15; i++) m_taps[i] = 0;
            end else begin
                s = 0;
                for (int i = 0; i < 15; i++) s += COEF[i] * m_taps[i];
                n_da    = lut_tab[m_phase[15:8]];
                m_phase = m_phase + 16'(m_fwc);
                m_fwc   = 1311 + s;
                m_da    = n_da;
                if (m_cnt == 9) begin
                    for (int i = 14; i > 0; i--) m_taps[i] = m_taps[i-1];
                    m_taps[0] = m_s2 ? 1 : -1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
                m_s2 = m_s1;
                m_s1 = data_in;
            end
            e.fwc = m_fwc;
            e.da  = m_da;
            exp_q.push_back(e);
        end
    end

    // Monitor: one scoreboard pop per cycle plus flag-enabled property checks.
    initial begin
        exp_t e;
        int   prev_fwc, cur, d;
        prev_fwc = 1311;
        forever begin
            @(negedge sys_clk);
            #1;
            cur = int'(fwc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty: got no expected entry, required one at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_fwc", cur, e.fwc);
                check("sb_da", int'(da_data), e.da);
            end
            check("da_clk", int'(da_clk), 1);
            if (range_strict) check_range("alt_fwc_range", cur, 984, 1638);
            if (range_incl)   check_range("rnd_fwc_range", cur, 983, 1639);
            if (delta_en && cur != prev_fwc) begin
                d = (cur > prev_fwc) ? cur - prev_fwc : prev_fwc - cur;
                check_range("alt_fwc_step", d, 1, 196);
            end
            if (alt_track) begin
                if (cur > alt_max) alt_max = cur;
                if (cur < alt_min) alt_min = cur;
            end
            prev_fwc = cur;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected finish before 3 ms");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int dmin, dmax;
        sys_rst_n = 1'b0;
        data_in   = 1'b0;
        step(5);
        check("rst_fwc", int'(fwc), 1311);
        check("rst_da", int'(da_data), 128);

        // Constant ones: full positive deviation.
        sys_rst_n = 1'b1;
        data_in   = 1'b1;
        step(250);
        check("ones_fwc", int'(fwc), 1639);
        dmin = 255; dmax = 0;
        repeat (100) begin
            step(1);
            if (int'(da_data) < dmin) dmin = int'(da_data);
            if (int'(da_data) > dmax) dmax = int'(da_data);
        end
        check("ones_fwc_hold", int'(fwc), 1639);
        check("ones_da_max", dmax, 255);
        check("ones_da_min", dmin, 0);

        // Constant zeros: full negative deviation.
        data_in = 1'b0;
        step(250);
        check("zeros_fwc", int'(fwc), 983);
        dmin = 255; dmax = 0;
        repeat (100) begin
            step(1);
            if (int'(da_data) < dmin) dmin = int'(da_data);
            if (int'(da_data) > dmax) dmax = int'(da_data);
        end
        check("zeros_da_max", dmax, 255);
        check("zeros_da_min", dmin, 0);

        // Alternating 1010: steady peaks are 1311 +/- 292.
        delta_en = 1;
        for (int p = 0; p < 100; p++) begin
            if (p == 5) begin
                alt_track    = 1;
                range_strict = 1;
            end
            data_in = 1'b1;
            step(50);
            data_in = 1'b0;
            step(50);
        end
        alt_track    = 0;
        range_strict = 0;
        delta_en     = 0;
        check("alt_fwc_max", alt_max, 1603);
        check("alt_fwc_min", alt_min, 1019);

        // Random bits with a one-clock reset pulse in the middle.
        range_incl = 1;
        for (int b = 0; b < 300; b++) begin
            data_in = 1'($urandom_range(0, 1));
            if (b == 150) begin
                step(23);
                sys_rst_n = 1'b0;
                #1;
                check("midrst_fwc", int'(fwc), 1311);
                check("midrst_da", int'(da_data), 128);
                step(1);
                sys_rst_n = 1'b1;
                step(26);
            end else begin
                step(50);
            end
        end
        range_incl = 0;
        step(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
